// File: rtl/vga_starfield_renderer.sv
// vga_starfield_renderer: rebuilds pixel coordinates from the VGA sync/active stream,
// draws a vertically scrolling LFSR starfield behind the game layer and drives
// registered RGB332 with delay-matched sync.
module vga_starfield_renderer #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [7:0]  STAR_THRESH = 8'hFC,
    parameter int          SCROLL_STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_ce,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       active_in,
    input  logic [7:0] game_rgb_in,
    input  logic       game_opaque_in,
    output logic       hs_out,
    output logic       vs_out,
    output logic [7:0] rgb_out,
    output logic [9:0] x_out,
    output logic [9:0] y_out,
    output logic       frame_tick
);
    localparam logic [9:0]  X_MAX = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_END = 10'(V_ACTIVE);
    localparam logic [10:0] V_MOD = 11'(V_ACTIVE);
    localparam logic [10:0] STEP  = 11'(SCROLL_STEP);
    localparam logic [15:0] MASK  = 16'hB400;

    logic [9:0]  x, y, scroll, scroll_nxt, ly;
    logic [10:0] scroll_sum, ly_sum;
    logic [15:0] lfsr, seed_mix, seed, lfsr_cur, lfsr_nxt;
    logic        active_d, vs_d, act_rise, act_fall, vs_fall, de, star;
    logic [7:0]  star_rgb, pix;

    // Edge detection against the samples taken at the previous pixel enable
    always_comb begin
        act_rise = active_in & ~active_d;
        act_fall = ~active_in & active_d;
        vs_fall  = vs_d & ~vs_in;
    end

    // Scroll advance and per-line seed; both sums stay below 2*V_ACTIVE so one subtract wraps them
    always_comb begin
        scroll_sum = {1'b0, scroll} + STEP;
        scroll_nxt = scroll_sum >= V_MOD ? 10'(scroll_sum - V_MOD) : scroll_sum[9:0];
        ly_sum     = {1'b0, y} + {1'b0, scroll};
        ly         = ly_sum >= V_MOD ? 10'(ly_sum - V_MOD) : ly_sum[9:0];
        seed_mix   = LFSR_SEED ^ {6'b0, ly};
        seed       = seed_mix == 16'h0 ? LFSR_SEED : seed_mix;
    end

    // First pixel of a run uses the fresh seed; later pixels use the stepped register
    always_comb begin
        lfsr_cur = act_rise ? seed : lfsr;
        lfsr_nxt = lfsr_cur[0] ? (lfsr_cur >> 1) ^ MASK : lfsr_cur >> 1;
    end

    // Star decision, star colour and foreground/background merge
    always_comb begin
        de       = active_in & (y < Y_END);
        star     = lfsr_cur[7:0] >= STAR_THRESH;
        star_rgb = lfsr_cur[15:14] == 2'b00 ? 8'h49 :
                   lfsr_cur[15:14] == 2'b01 ? 8'h92 :
                   lfsr_cur[15:14] == 2'b10 ? 8'hB6 : 8'hFF;
        pix      = !de ? 8'h00 : game_opaque_in ? game_rgb_in : star ? star_rgb : 8'h00;
    end

    // Coordinate tracker, scroll offset and LFSR state, advancing only on pixel enables
    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            scroll   <= '0;
            lfsr     <= LFSR_SEED;
            active_d <= 1'b0;
            vs_d     <= 1'b1;
        end else if (pix_ce) begin
            active_d <= active_in;
            vs_d     <= vs_in;
            x        <= !active_in ? 10'd0 : x == X_MAX ? x : x + 10'd1;
            y        <= vs_fall ? 10'd0 : act_fall && y != Y_END ? y + 10'd1 : y;
            if (vs_fall)
                scroll <= scroll_nxt;
            if (active_in)
                lfsr <= lfsr_nxt;
        end
    end

    // Registered pixel and sync outputs; frame_tick is a single-clk strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_out     <= 1'b1;
            vs_out     <= 1'b1;
            rgb_out    <= 8'h00;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pix_ce & vs_fall;
            if (pix_ce) begin
                hs_out  <= hs_in;
                vs_out  <= vs_in;
                rgb_out <= pix;
            end
        end
    end

    assign x_out = x;
    assign y_out = y;
endmodule
